// File: rtl/wb_dram_pkg.sv
// wb_dram_pkg: shared widths, request type, FSM states and out-of-range pattern for wb_dram_responder
package wb_dram_pkg;
  localparam int WB_DRAM_ADR_W = 29;
  localparam int WB_DRAM_DAT_W = 64;
  localparam int WB_DRAM_SEL_W = 8;
  localparam logic [WB_DRAM_DAT_W-1:0] WB_DRAM_OOR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;
  typedef struct packed {
    logic [WB_DRAM_ADR_W-1:0] adr;
    logic [WB_DRAM_DAT_W-1:0] dat;
    logic [WB_DRAM_SEL_W-1:0] sel;
    logic                     we;
  } wb_dram_req_t;
  typedef enum logic {IDLE, WAIT} wb_dram_state_t;
endpackage

// File: rtl/wb_dram_responder_if.sv
// wb_dram_responder_if: pipelined Wishbone B4 request/response bus for the 64-bit DRAM port
interface wb_dram_responder_if;
  import wb_dram_pkg::*;
  logic [WB_DRAM_ADR_W-1:0] wb_adr;
  logic [WB_DRAM_DAT_W-1:0] wb_dat_w;
  logic [WB_DRAM_SEL_W-1:0] wb_sel;
  logic                     wb_cyc;
  logic                     wb_stb;
  logic                     wb_we;
  logic [WB_DRAM_DAT_W-1:0] wb_dat_r;
  logic                     wb_ack;
  logic                     wb_stall;
  modport master (output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we, input wb_dat_r, wb_ack, wb_stall);
  modport slave (input wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we, output wb_dat_r, wb_ack, wb_stall);
endinterface

// File: rtl/wb_dram_req_fifo.sv
// wb_dram_req_fifo: 2-entry request FIFO with synchronous flush
module wb_dram_req_fifo
  import wb_dram_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  wb_dram_req_t din,
  output wb_dram_req_t dout,
  output logic         full,
  output logic         empty
);
  wb_dram_req_t slot [2];
  logic         wp;
  logic         rp;
  logic [1:0]   count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      wp    <= wp ^ push;
      rp    <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  // payload storage carries no reset; only the pointers define validity
  always_ff @(posedge clk)
    if (push && !flush) slot[wp] <= din;
  assign dout  = slot[rp];
  assign full  = count == 2'd2;
  assign empty = count == 2'd0;
endmodule

// File: rtl/wb_dram_responder.sv
// wb_dram_responder: Wishbone B4 DRAM stand-in with flop memory and LAT-cycle service; WB_DRAM_RESP_OOR_EN enables out-of-range detection
module wb_dram_responder
  import wb_dram_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 9,
  parameter int LAT            = 2
) (
  input logic                system_clk,
  input logic                rst_n,
  wb_dram_responder_if.slave wb
);
  wb_dram_req_t                 head;
  wb_dram_req_t                 cur;
  wb_dram_state_t               state;
  logic [3:0]                   cnt;
  logic [WB_DRAM_DAT_W-1:0]     mem [2**MEM_WORDS_LOG2];
  logic [WB_DRAM_DAT_W-1:0]     dat_r;
  logic                         ack;
  logic                         full;
  logic                         empty;
  logic                         push;
  logic                         pop;
  logic                         flush;
  logic                         fire;
  logic                         oor;
  logic                         commit;
  logic [MEM_WORDS_LOG2-1:0]    idx;
  assign flush  = !wb.wb_cyc;
  assign push   = wb.wb_cyc & wb.wb_stb & !full;
  assign pop    = state == IDLE && !empty;
  assign fire   = state == WAIT && cnt == 4'd0 && wb.wb_cyc;
  assign idx    = cur.adr[MEM_WORDS_LOG2-1:0];
`ifdef WB_DRAM_RESP_OOR_EN
  assign oor    = |cur.adr[WB_DRAM_ADR_W-1:MEM_WORDS_LOG2];
`else
  logic unused_adr;
  assign oor        = 1'b0;
  assign unused_adr = ^cur.adr[WB_DRAM_ADR_W-1:MEM_WORDS_LOG2];
`endif
  assign commit = fire & cur.we & !oor;
  wb_dram_req_fifo u_fifo (
    .clk  (system_clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  ('{adr: wb.wb_adr, dat: wb.wb_dat_w, sel: wb.wb_sel, we: wb.wb_we}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  // a dropped cyc wins over everything, including an ack due on the same edge
  always_ff @(posedge system_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      dat_r <= '0;
      cur   <= '0;
    end else if (flush) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (state == IDLE) begin
        if (!empty) begin
          cur   <= head;
          cnt   <= 4'(LAT - 1);
          state <= WAIT;
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        ack   <= 1'b1;
        state <= IDLE;
        if (!cur.we) dat_r <= oor ? WB_DRAM_OOR_PATTERN : mem[idx];
      end
    end
  always_ff @(posedge system_clk)
    if (commit)
      for (int i = 0; i < WB_DRAM_SEL_W; i++)
        if (cur.sel[i]) mem[idx][8*i +: 8] <= cur.dat[8*i +: 8];
  assign wb.wb_ack   = ack;
  assign wb.wb_dat_r = dat_r;
  assign wb.wb_stall = full;
endmodule
